// File: rtl/mascota_pkg.sv
// Shared definitions for the virtual-pet core: button indices, button FSM
// states and default timing constants.
package mascota_pkg;

    localparam int BTN_CARINO   = 0;
    localparam int BTN_COMIDA   = 1;
    localparam int BTN_MEDICINA = 2;
    localparam int BTN_DORMIR   = 3;
    localparam int BTN_TEST     = 4;
    localparam int BTN_RESETEO  = 5;
    localparam int N_BTN_DEF    = 6;

    localparam int DEF_DEBOUNCE_CYC = 500000;
    localparam int DEF_TICK_DIV     = 50000000;
    localparam int DEF_HOLD_TICKS   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

endpackage

// File: rtl/antirrebote.sv
// One-button conditioner: 2-flop synchroniser, debounce filter and a
// press/hold FSM that emits one-cycle press and hold pulses.
module antirrebote
    import mascota_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_hold
);

    localparam int DC_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    logic            r_s1;
    logic            r_s2;
    logic [DC_W-1:0] r_dc;
    logic            r_level;
    logic            r_press;
    logic            r_hold;
    logic [3:0]      r_hc;
    btn_state_t      r_state;

    btn_state_t      w_state_d;
    logic            w_flip;
    logic            w_rise;
    logic            w_fall;
    logic            w_count;
    logic [3:0]      w_hc_inc;
    logic            w_hold_hit;
    logic            w_press_d;
    logic            w_hold_d;
    logic [3:0]      w_hc_d;

    assign w_flip     = (r_s2 != r_level) && (r_dc == DC_W'(DEBOUNCE_CYC - 1));
    assign w_rise     = w_flip && r_s2;
    assign w_fall     = w_flip && !r_s2;
    // The press cycle itself never counts a tick, so latency stays within one second.
    assign w_count    = i_tick && !r_press;
    assign w_hc_inc   = (r_hc == 4'hF) ? r_hc : r_hc + 4'd1;
    assign w_hold_hit = w_count && (w_hc_inc == 4'(HOLD_TICKS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_dc    <= '0;
            r_level <= 1'b0;
            r_state <= IDLE;
            r_press <= 1'b0;
            r_hold  <= 1'b0;
            r_hc    <= 4'd0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            if (r_s2 == r_level) begin
                r_dc <= '0;
            end else if (w_flip) begin
                r_dc    <= '0;
                r_level <= r_s2;
            end else begin
                r_dc <= r_dc + 1'b1;
            end
            r_state <= w_state_d;
            r_press <= w_press_d;
            r_hold  <= w_hold_d;
            r_hc    <= w_hc_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_state_d = PRESSED;
            PRESSED: begin
                if (w_fall)          w_state_d = IDLE;
                else if (w_hold_hit) w_state_d = HELD;
            end
            HELD:    if (w_fall) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_press_d = 1'b0;
        w_hold_d  = 1'b0;
        w_hc_d    = r_hc;
        case (r_state)
            IDLE: begin
                w_press_d = w_rise;
                if (w_rise) w_hc_d = 4'd0;
            end
            PRESSED: begin
                w_hold_d = w_hold_hit && !w_fall;
                if (w_count) w_hc_d = w_hc_inc;
            end
            default: ;
        endcase
    end

    assign o_level = r_level;
    assign o_press = r_press;
    assign o_hold  = r_hold;

endmodule

// File: rtl/acond_botones.sv
// Input conditioning for the pet core: shared 1 s tick, one antirrebote per
// button and the modo_test toggle driven by the test button's hold event.
module acond_botones
    import mascota_pkg::*;
#(
    parameter int N_BTN        = N_BTN_DEF,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int TEST_IDX     = BTN_TEST
) (
    input  logic             clk,
    input  logic             reseteo,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_hold,
    output logic             tick_1s,
    output logic             modo_test
);

    localparam int TC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [TC_W-1:0] r_tcnt;
    logic            r_tick;
    logic            r_modo;

    // Registered tick is raised one cycle early so it is high while the count reads TICK_DIV-1.
    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            r_tcnt <= '0;
            r_tick <= 1'b0;
            r_modo <= 1'b0;
        end else begin
            r_tcnt <= (r_tcnt == TC_W'(TICK_DIV - 1)) ? '0 : r_tcnt + 1'b1;
            r_tick <= (r_tcnt == TC_W'(TICK_DIV - 2));
            r_modo <= r_modo ^ btn_hold[TEST_IDX];
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        antirrebote #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_TICKS   (HOLD_TICKS)
        ) u_antirrebote (
            .i_clk   (clk),
            .i_rst   (reseteo),
            .i_raw   (btn_raw[g]),
            .i_tick  (r_tick),
            .o_level (btn_level[g]),
            .o_press (btn_press[g]),
            .o_hold  (btn_hold[g])
        );
    end

    assign tick_1s   = r_tick;
    assign modo_test = r_modo;

endmodule

// File: tb/tb_acond_botones.sv
// Scoreboard bench for acond_botones: a cycle-level reference model pushes the
// expected outputs after every edge and a monitor compares them on the falling edge.
module tb_acond_botones;

    localparam int NB   = 6;
    localparam int DEB  = 4;
    localparam int TDIV = 10;
    localparam int HOLD = 2;
    localparam int TIDX = 4;

    logic          clk = 1'b0;
    logic          reseteo;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_hold;
    logic          tick_1s, modo_test;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] hld;
        logic          tick;
        logic          modo;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   hold4_seen = 0;

    acond_botones #(
        .N_BTN(NB), .DEBOUNCE_CYC(DEB), .TICK_DIV(TDIV),
        .HOLD_TICKS(HOLD), .TEST_IDX(TIDX)
    ) dut (
        .clk(clk), .reseteo(reseteo), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_hold(btn_hold),
        .tick_1s(tick_1s), .modo_test(modo_test)
    );

    always #5 clk = ~clk;

    // Reference model: the debounced level follows the synchronised input once it
    // has disagreed for DEB consecutive cycles; holds count ticks after the press.
    initial begin : model
        int            e;
        logic [NB-1:0] s1m, s2m, lvl, prs, hld, nl, np, nh;
        logic          tick_c, modo_c, ntick;
        int            run[NB];
        int            ticks[NB];
        logic          held[NB];
        forever begin
            @(posedge clk);
            if (reseteo) begin
                e = 0; s1m = '0; s2m = '0; lvl = '0; prs = '0; hld = '0;
                tick_c = 1'b0; modo_c = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    run[b] = 0; ticks[b] = 0; held[b] = 1'b0;
                end
            end else begin
                e++;
                ntick = ((e % TDIV) == TDIV - 1);
                nl = lvl; np = '0; nh = '0;
                for (int b = 0; b < NB; b++) begin
                    logic rose, fell;
                    rose = 1'b0; fell = 1'b0;
                    if (s2m[b] != lvl[b]) begin
                        run[b]++;
                        if (run[b] == DEB) begin
                            run[b] = 0;
                            if (s2m[b]) rose = 1'b1; else fell = 1'b1;
                        end
                    end else begin
                        run[b] = 0;
                    end
                    if (rose) begin
                        np[b] = 1'b1; held[b] = 1'b0; ticks[b] = 0; nl[b] = 1'b1;
                    end else if (fell) begin
                        held[b] = 1'b0; nl[b] = 1'b0;
                    end else if (lvl[b] && !held[b] && tick_c && !prs[b]) begin
                        ticks[b]++;
                        if (ticks[b] == HOLD) begin
                            nh[b] = 1'b1; held[b] = 1'b1;
                        end
                    end
                end
                modo_c = modo_c ^ hld[TIDX];
                s2m = s1m; s1m = btn_raw;
                lvl = nl; prs = np; hld = nh; tick_c = ntick;
                q.push_back('{lvl: lvl, prs: prs, hld: hld, tick: tick_c, modo: modo_c});
            end
        end
    end

    initial begin : monitor
        exp_t x, a;
        forever begin
            @(negedge clk);
            if (!reseteo && q.size() > 0) begin
                x = q.pop_front();
                a = '{lvl: btn_level, prs: btn_press, hld: btn_hold, tick: tick_1s, modo: modo_test};
                if (btn_hold[TIDX]) hold4_seen++;
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL outputs t=%0t got lvl=%b prs=%b hld=%b tick=%b modo=%b exp lvl=%b prs=%b hld=%b tick=%b modo=%b",
                             $time, a.lvl, a.prs, a.hld, a.tick, a.modo,
                             x.lvl, x.prs, x.hld, x.tick, x.modo);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    task automatic hold4_phase(input logic exp_modo);
        hold4_seen = 0;
        btn_raw[4] = 1'b1;
        idle(40);
        btn_raw[4] = 1'b0;
        idle(12);
        check("hold4_once", hold4_seen, 1);
        check("modo_after_hold", modo_test, exp_modo);
    endtask

    initial begin : driver
        int n;
        reseteo = 1'b1;
        btn_raw = '0;
        #1;
        check("reset_outputs", {btn_level, btn_press, btn_hold, tick_1s, modo_test}, 0);
        idle(3);
        reseteo = 1'b0;
        idle(32);

        // Short glitch on button 0 must never reach the debounced level.
        btn_raw[0] = 1'b1;
        idle(3);
        btn_raw[0] = 1'b0;
        idle(10);

        // Press latency on button 3.
        btn_raw[3] = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (btn_level[3]) break;
        end
        check("press_latency", n, 6);
        check("press_pulse", btn_press[3], 1);
        @(negedge clk);
        btn_raw[3] = 1'b0;
        idle(10);

        hold4_phase(1'b1);
        hold4_phase(1'b0);

        btn_raw[2:1] = 2'b11;
        idle(10);
        btn_raw[2:1] = 2'b00;
        idle(10);

        // Async reset while button 4 is in HELD with modo_test set.
        btn_raw[4] = 1'b1;
        idle(30);
        check("modo_before_reset", modo_test, 1);
        @(posedge clk); #3;
        reseteo = 1'b1;
        #1;
        check("async_reset_outputs", {btn_level, btn_press, btn_hold, tick_1s, modo_test}, 0);
        q.delete();
        idle(2);
        reseteo = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (btn_press[4]) break;
        end
        check("repress_after_reset", n, 6);
        @(negedge clk);
        btn_raw[4] = 1'b0;
        idle(10);

        // Random bursty stimulus.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acond_botones.md
# acond_botones

Input-conditioning stage for the virtual-pet core, sitting between the board push-buttons and the pet state machine. It provides:
- a 2-flop synchroniser, debounce filter and per-button press/hold detection for every button;
- the shared 1 s tick;
- the `modo_test` toggle.

Its one-cycle pulses drive the pet core's care inputs (Carino, Comida, Medicina, Dormir), test and reset requests. This replaces per-block ad-hoc counting of raw levels.

## Interface
Parameters:
- `N_BTN`, 6: number of buttons (0 Carino, 1 Comida, 2 Medicina, 3 Dormir, 4 test, 5 reseteo-request)
- `DEBOUNCE_CYC`, 500000: cycles a synchronised input must stay stable before the debounced level follows (10 ms at 50 MHz); ≥ 2
- `TICK_DIV`, 50000000: clk cycles per `tick_1s` pulse; ≥ 2
- `HOLD_TICKS`, 5: `tick_1s` pulses counted while held before a hold event; 1..15
- `TEST_IDX`, 4: button whose hold event toggles `modo_test`

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `reseteo`  in  1  asynchronous, active-high reset
- `btn_raw`  in  N_BTN  raw buttons, active-high after board inversion, asynchronous to clk
- `btn_level`  out  N_BTN  debounced level
- `btn_press`  out  N_BTN  one-cycle pulse on debounced rising edge
- `btn_hold`  out  N_BTN  one-cycle pulse, once per press, on the HOLD_TICKS-th tick while held
- `tick_1s`  out  1  one-cycle pulse every TICK_DIV cycles
- `modo_test`  out  1  test-mode flag

## Operation
- Reset, asynchronous: all outputs 0; synchronisers, debounce/hold counters and tick counter 0; every button FSM in IDLE.
- Tick counter:
  - counts 0..TICK_DIV-1 and wraps;
  - `tick_1s` asserts in the cycle the count equals TICK_DIV-1;
  - it is free-running and independent of buttons.
- Per button, `s2` is the synchroniser output.
- Debounce counter `dc` (width clog2(DEBOUNCE_CYC)):
  - cleared whenever `s2 == btn_level`;
  - otherwise increments;
  - when `dc == DEBOUNCE_CYC-1` and `s2 != btn_level`, `btn_level <= s2` and `dc <= 0`;
  - glitches shorter than DEBOUNCE_CYC cycles never reach `btn_level`.
- Per-button FSM:
  - IDLE → PRESSED on debounced rise: `btn_press` = 1 that cycle, hold counter `hc` = 0.
  - PRESSED:
    - each `tick_1s` increments `hc` (4 bits, saturating);
    - when the increment reaches HOLD_TICKS → HELD, `btn_hold` = 1 that cycle;
    - debounced fall → IDLE, no hold.
  - HELD: no further pulses; debounced fall → IDLE.
- A `tick_1s` coinciding with the debounced rise is not counted, so hold latency is between HOLD_TICKS-1 and HOLD_TICKS seconds.
- `modo_test` toggles on every `btn_hold[TEST_IDX]`; `btn_press[TEST_IDX]` alone does not affect it.
- Buttons are fully independent. Simultaneous presses produce simultaneous pulses; no priority or masking.

## Timing
- Raw rise sampled at edge 0 → `s2` high after edge 2 → `btn_level` and `btn_press` high after edge DEBOUNCE_CYC+2. Release latency is identical.
- All outputs are registered; no combinational path from `btn_raw`.
- `btn_press` and `btn_hold` are exactly one cycle wide and never asserted in the same cycle for one button, because HOLD_TICKS ≥ 1.
- `modo_test` changes the cycle after `btn_hold[TEST_IDX]`.
- Reset mid-press: outputs drop immediately. A button still held after release of reset is seen as a fresh press after DEBOUNCE_CYC+2 cycles.

## Structure
- Shared package `mascota_pkg`:
  - button index constants (`BTN_CARINO`..`BTN_RESETEO`);
  - FSM state type {IDLE, PRESSED, HELD};
  - default timing constants.
- Sub-module `antirrebote`: synchroniser, debounce counter, FSM and hold counter for one button. Instantiated N_BTN times.
- The top level holds only the tick counter, the `modo_test` flag and the generate loop.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, TICK_DIV=10, HOLD_TICKS=2.
- Reset release, inputs 0 → all outputs 0; `tick_1s` pulses on cycles 9, 19, 29 after reset, width 1.
- `btn_raw[0]` high for 3 cycles then low → `btn_level[0]` and `btn_press[0]` never assert.
- `btn_raw[3]` rises and stays high → `btn_level[3]` and a single `btn_press[3]` pulse 6 cycles later. Release → `btn_level[3]` low 6 cycles after release, no `btn_hold`.
- `btn_raw[4]` held 40 cycles → `btn_hold[4]` on the 2nd tick after the press, exactly once; `modo_test` 0→1 next cycle. Repeat → `modo_test` 1→0.
- `btn_raw[1]` and `btn_raw[2]` rise together → `btn_press[1]` and `btn_press[2]` in the same cycle.
- `reseteo` pulsed while button 4 is in HELD with `modo_test`=1 → all outputs 0 asynchronously. Button still high afterwards → new `btn_press[4]` 6 cycles after reset release.
